// File: rtl/autosym_pla_eval_pkg.sv
// Shared widths, cube record and FSM state encoding for the PLA cover evaluator.
// The optional input projection is enabled by defining AUTOSYM_PROJ_EN.
package autosym_pkg;

   localparam int unsigned N_IN      = 10;
   localparam int unsigned N_OUT     = 1;
   localparam int unsigned MAX_CUBES = 32;
   localparam int unsigned CW        = $clog2(MAX_CUBES + 1);
   localparam int unsigned AW        = (MAX_CUBES > 1) ? $clog2(MAX_CUBES) : 1;
   localparam int unsigned PW        = (N_IN > 1) ? $clog2(N_IN) : 1;

   typedef struct packed {
      logic [N_IN-1:0]  care;
      logic [N_IN-1:0]  val;
      logic [N_OUT-1:0] out;
   } cube_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HOLD
   } state_e;

   // Clamp a requested cube count to the memory depth
   function automatic logic [CW-1:0] sat_num(input logic [CW-1:0] n);
      return (32'(n) > MAX_CUBES) ? CW'(MAX_CUBES) : n;
   endfunction

endpackage

// File: rtl/autosym_pla_eval_if.sv
// Configuration, query and result signals of the PLA cover evaluator.
// Projection-matrix write signals exist only when AUTOSYM_PROJ_EN is defined.
interface autosym_pla_eval_if;
   import autosym_pkg::*;

   logic              cfg_we;
   logic [CW-1:0]     cfg_addr;
   logic [N_IN-1:0]   cfg_care;
   logic [N_IN-1:0]   cfg_val;
   logic [N_OUT-1:0]  cfg_out;
   logic              cfg_num_we;
   logic [CW-1:0]     cfg_num;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic [N_IN-1:0]   x;
   logic              out_valid;
   logic              out_ready;
   logic [N_OUT-1:0]  y;
`ifdef AUTOSYM_PROJ_EN
   logic              proj_we;
   logic [PW-1:0]     proj_row;
   logic [N_IN-1:0]   proj_mask;

   modport master (
      output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out, cfg_num_we, cfg_num,
      output in_valid, x, out_ready, proj_we, proj_row, proj_mask,
      input  busy, in_ready, out_valid, y
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out, cfg_num_we, cfg_num,
      input  in_valid, x, out_ready, proj_we, proj_row, proj_mask,
      output busy, in_ready, out_valid, y
   );
`else
   modport master (
      output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out, cfg_num_we, cfg_num,
      output in_valid, x, out_ready,
      input  busy, in_ready, out_valid, y
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out, cfg_num_we, cfg_num,
      input  in_valid, x, out_ready,
      output busy, in_ready, out_valid, y
   );
`endif

endinterface

// File: rtl/autosym_pla_eval_cube_match.sv
// Combinational cube test: every cared-for literal must agree with the latched vector.
module autosym_cube_match
   import autosym_pkg::*;
(
   input  cube_t           cube,
   input  logic [N_IN-1:0] xr,
   output logic            match_c
);

   assign match_c = &(~cube.care | ~(xr ^ cube.val));

endmodule

// File: rtl/autosym_pla_eval.sv
// Sequential sum-of-products evaluator: scans a loadable cube cover one cube per cycle.
// Define AUTOSYM_PROJ_EN to add a GF(2) projection of the query before evaluation.
module autosym_pla_eval
   import autosym_pkg::*;
(
   input logic               clk,
   input logic               rst,
   autosym_pla_eval_if.slave bus
);

   state_e            state_q, state_d;
   logic [CW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     num_q, num_d;
   logic [N_OUT-1:0]  acc_q, acc_d;
   logic [N_OUT-1:0]  y_q, y_d;
   logic [N_IN-1:0]   xr_q, xr_d;
   logic [N_IN-1:0]   xp_c;
   logic              in_ready_q, out_valid_q, busy_q;
   logic              cfg_ok_c;
   logic              hit_c;
   cube_t             cur_c;
   cube_t             mem [MAX_CUBES];

   // Configuration is only safe while idle and not simultaneously accepting a query
   assign cfg_ok_c = (state_q == IDLE) && !bus.in_valid;

   always_ff @(posedge clk) begin
      if (cfg_ok_c && bus.cfg_we && (32'(bus.cfg_addr) < MAX_CUBES)) begin
         mem[bus.cfg_addr[AW-1:0]] <= '{care: bus.cfg_care, val: bus.cfg_val, out: bus.cfg_out};
      end
   end

   assign cur_c = mem[idx_q[AW-1:0]];

   autosym_cube_match u_match (
      .cube    (cur_c),
      .xr      (xr_q),
      .match_c (hit_c)
   );

`ifdef AUTOSYM_PROJ_EN
   logic [N_IN-1:0] proj_q [N_IN];

   // Projection rows reset to the identity so an unconfigured block passes x through
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < int'(N_IN); j++) begin
            proj_q[j] <= N_IN'(1) << j;
         end
      end else if (cfg_ok_c && bus.proj_we && (32'(bus.proj_row) < N_IN)) begin
         proj_q[bus.proj_row] <= bus.proj_mask;
      end
   end

   always_comb begin
      xp_c = '0;
      for (int j = 0; j < int'(N_IN); j++) begin
         xp_c[j] = ^(bus.x & proj_q[j]);
      end
   end
`else
   assign xp_c = bus.x;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         num_q       <= '0;
         acc_q       <= '0;
         y_q         <= '0;
         xr_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         num_q       <= num_d;
         acc_q       <= acc_d;
         y_q         <= y_d;
         xr_q        <= xr_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == HOLD);
         busy_q      <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      num_d   = num_q;
      acc_d   = acc_q;
      y_d     = y_q;
      xr_d    = xr_q;

      if (cfg_ok_c && bus.cfg_num_we) begin
         num_d = sat_num(bus.cfg_num);
      end

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               xr_d  = xp_c;
               acc_d = '0;
               idx_d = '0;
               if (num_q == '0) begin
                  state_d = HOLD;
                  y_d     = '0;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            // Full scan every time keeps latency independent of the data
            acc_d = acc_q | ({N_OUT{hit_c}} & cur_c.out);
            idx_d = idx_q + CW'(1);
            if (idx_q == num_q - CW'(1)) begin
               state_d = HOLD;
               y_d     = acc_d;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.y         = y_q;

endmodule
